// File: rtl/ifetch_queue.sv
// Instruction fetch queue: walks a fetch pointer through instruction memory and
// buffers {insn, pc} pairs for decode; redirect flushes and restarts fetch.
module ifetch_queue #(
   parameter int AW    = 16,
   parameter int IW    = 16,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          redirect,
   input  logic [AW-1:0] redirect_pc,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [IW-1:0] mem_rdata,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [IW-1:0] out_insn,
   output logic [AW-1:0] out_pc
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [IW-1:0] insn_mem [DEPTH];
   logic [AW-1:0] pc_mem   [DEPTH];
   logic [AW-1:0] fpc;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;

   // The request is held only while there is room, so an outstanding request
   // stays stable until it is acked or abandoned by redirect/reset.
   assign mem_req   = (count < CW'(DEPTH)) && !redirect && !rst;
   assign mem_addr  = fpc;
   assign out_valid = (count != '0) && !redirect && !rst;
   assign out_insn  = insn_mem[head];
   assign out_pc    = pc_mem[head];

   assign push = mem_req && mem_ack;
   assign pop  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc   <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (redirect) begin
         fpc   <= redirect_pc;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= tail + PW'(1);
            fpc  <= fpc + AW'(1);
         end
         if (pop) begin
            head <= head + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; push is already masked by rst and redirect.
   always_ff @(posedge clk) begin
      if (push) begin
         insn_mem[tail] <= mem_rdata;
         pc_mem[tail]   <= fpc;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: memory model returns addr^0xA5A5 whenever acked.
module tb_ifetch_queue;

   logic        clk;
   logic        rst;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_insn;
   logic [15:0] out_pc;

   int n_checks = 0;
   int n_errors = 0;

   ifetch_queue #(.AW(16), .IW(16), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn), .out_pc(out_pc)
   );

   assign mem_rdata = mem_addr ^ 16'hA5A5;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change at negedge; outputs are sampled 1 time unit later.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; redirect = 1'b0; mem_ack = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h4321; mem_ack = 1'b1; out_ready = 1'b1;
      #1;
      n_checks++;
      if (mem_req !== 1'b0) begin n_errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      @(negedge clk);
      rst = 1'b0; redirect = 1'b0; mem_ack = 1'b0; out_ready = 1'b0;
      #1;
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0000)
         begin n_errors++; $display("FAIL post_reset_req got req=%b addr=%h want req=1 addr=0000", mem_req, mem_addr); end
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL post_reset_valid got %b want 0", out_valid); end
   endtask

   task automatic test_stream();
      do_reset();
      mem_ack = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         n_checks++;
         if (mem_req !== 1'b1 || mem_addr !== 16'(k))
            begin n_errors++; $display("FAIL stream_addr[%0d] got req=%b addr=%h want req=1 addr=%h", k, mem_req, mem_addr, 16'(k)); end
         if (k == 0) begin
            n_checks++;
            if (out_valid !== 1'b0) begin n_errors++; $display("FAIL stream_first_valid got %b want 0", out_valid); end
         end else begin
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 16'(k-1) || out_insn !== (16'(k-1) ^ 16'hA5A5))
               begin n_errors++; $display("FAIL stream_out[%0d] got v=%b pc=%h insn=%h want v=1 pc=%h insn=%h",
                     k, out_valid, out_pc, out_insn, 16'(k-1), 16'(k-1) ^ 16'hA5A5); end
         end
         @(negedge clk);
      end
      mem_ack = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      do_reset();
      mem_ack = 1'b1; out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_checks++;
         if (mem_req !== 1'b1 || mem_addr !== 16'(k))
            begin n_errors++; $display("FAIL bp_fill[%0d] got req=%b addr=%h want req=1 addr=%h", k, mem_req, mem_addr, 16'(k)); end
         @(negedge clk);
      end
      #1;
      n_checks++;
      if (mem_req !== 1'b0) begin n_errors++; $display("FAIL bp_full_req got %b want 0", mem_req); end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      n_checks++;
      if (mem_req !== 1'b0 || out_valid !== 1'b1 || out_pc !== 16'h0000 || out_insn !== 16'hA5A5)
         begin n_errors++; $display("FAIL bp_pop got req=%b v=%b pc=%h insn=%h want req=0 v=1 pc=0000 insn=a5a5",
               mem_req, out_valid, out_pc, out_insn); end
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0004 || out_pc !== 16'h0001)
         begin n_errors++; $display("FAIL bp_refetch got req=%b addr=%h pc=%h want req=1 addr=0004 pc=0001", mem_req, mem_addr, out_pc); end
      @(negedge clk);
      #1;
      n_checks++;
      if (mem_req !== 1'b0) begin n_errors++; $display("FAIL bp_refull_req got %b want 0", mem_req); end
      mem_ack = 1'b0;
   endtask

   task automatic test_wait_states();
      do_reset();
      mem_ack = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++;
         if (mem_req !== 1'b1 || mem_addr !== 16'h0002)
            begin n_errors++; $display("FAIL wait_hold[%0d] got req=%b addr=%h want req=1 addr=0002", k, mem_req, mem_addr); end
         @(negedge clk);
      end
      mem_ack = 1'b1;
      #1;
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h0002)
         begin n_errors++; $display("FAIL wait_ack got req=%b addr=%h want req=1 addr=0002", mem_req, mem_addr); end
      @(negedge clk);
      mem_ack = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_checks++;
         if (out_valid !== 1'b1 || out_pc !== 16'(k) || mem_addr !== 16'h0003)
            begin n_errors++; $display("FAIL wait_drain[%0d] got v=%b pc=%h addr=%h want v=1 pc=%h addr=0003",
                  k, out_valid, out_pc, mem_addr, 16'(k)); end
         @(negedge clk);
      end
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL wait_single_push got v=%b want 0", out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_redirect();
      do_reset();
      mem_ack = 1'b1; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      redirect = 1'b1; redirect_pc = 16'h1234;
      #1;
      n_checks++;
      if (mem_req !== 1'b0 || out_valid !== 1'b0)
         begin n_errors++; $display("FAIL redir_cycle got req=%b v=%b want req=0 v=0", mem_req, out_valid); end
      @(negedge clk);
      redirect = 1'b0; mem_ack = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h1234)
         begin n_errors++; $display("FAIL redir_after got v=%b req=%b addr=%h want v=0 req=1 addr=1234", out_valid, mem_req, mem_addr); end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0; out_ready = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== 16'h1234 || out_insn !== (16'h1234 ^ 16'hA5A5))
         begin n_errors++; $display("FAIL redir_first_out got v=%b pc=%h insn=%h want v=1 pc=1234 insn=%h",
               out_valid, out_pc, out_insn, 16'h1234 ^ 16'hA5A5); end
      @(negedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL redir_flushed got v=%b want 0", out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back_wrap();
      do_reset();
      redirect = 1'b1; redirect_pc = 16'h5555; mem_ack = 1'b1;
      @(negedge clk);
      redirect_pc = 16'hFFFF;
      @(negedge clk);
      redirect = 1'b0; out_ready = 1'b1;
      #1;
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'hFFFF)
         begin n_errors++; $display("FAIL wrap_addr0 got req=%b addr=%h want req=1 addr=ffff", mem_req, mem_addr); end
      @(negedge clk);
      #1;
      n_checks++;
      if (mem_addr !== 16'h0000 || out_valid !== 1'b1 || out_pc !== 16'hFFFF)
         begin n_errors++; $display("FAIL wrap_step1 got addr=%h v=%b pc=%h want addr=0000 v=1 pc=ffff", mem_addr, out_valid, out_pc); end
      @(negedge clk);
      #1;
      n_checks++;
      if (mem_addr !== 16'h0001 || out_valid !== 1'b1 || out_pc !== 16'h0000 || out_insn !== 16'hA5A5)
         begin n_errors++; $display("FAIL wrap_step2 got addr=%h v=%b pc=%h insn=%h want addr=0001 v=1 pc=0000 insn=a5a5",
               mem_addr, out_valid, out_pc, out_insn); end
      mem_ack = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      mem_ack = 1'b1; out_ready = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1; redirect = 1'b1; redirect_pc = 16'h7777;
      #1;
      n_checks++;
      if (mem_req !== 1'b0 || out_valid !== 1'b0)
         begin n_errors++; $display("FAIL rstmid_during got req=%b v=%b want req=0 v=0", mem_req, out_valid); end
      @(negedge clk);
      rst = 1'b0; redirect = 1'b0; mem_ack = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0000)
         begin n_errors++; $display("FAIL rstmid_after got v=%b req=%b addr=%h want v=0 req=1 addr=0000", out_valid, mem_req, mem_addr); end
      // Two entries queued plus a pending request at addr 2, then reset.
      mem_ack = 1'b1;
      repeat (2) @(negedge clk);
      mem_ack = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || mem_addr !== 16'h0000)
         begin n_errors++; $display("FAIL rstmid_pending got v=%b addr=%h want v=0 addr=0000", out_valid, mem_addr); end
   endtask

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; mem_ack = 1'b0; out_ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_wait_states();
      test_redirect();
      test_back_to_back_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameters (name, default, meaning), SHALL be:
- AW, 16: fetch address width.
- IW, 16: instruction width.
- DEPTH, 4: queue entries; power of two, >=2.
REQ-002 Ports (name, direction, width, meaning), SHALL be:
- clk, in, 1: clock.
- rst, in, 1: reset.
- redirect, in, 1: flush the queue and restart fetch at redirect_pc.
- redirect_pc, in, AW: new fetch address.
- mem_req, out, 1: instruction memory request.
- mem_addr, out, AW: request address.
- mem_ack, in, 1: memory accepts the request; mem_rdata is valid in the same cycle.
- mem_rdata, in, IW: fetched word.
- out_valid, out, 1: the head entry is presented to decode.
- out_ready, in, 1: decode consumes the head entry.
- out_insn, out, IW: head instruction.
- out_pc, out, AW: address of the head instruction.
REQ-003 Reset SHALL be rst, synchronous, active-high; the clock SHALL be clk.

Function
REQ-004 The block SHALL hold a fetch pointer fpc (AW bits) and a DEPTH-entry FIFO of {insn, pc} pairs, plus an occupancy count (0..DEPTH).
REQ-005 mem_req SHALL be (count < DEPTH) && !redirect && !rst.
- mem_addr SHALL equal fpc.
REQ-006 A fetch SHALL complete only when mem_req && mem_ack in the same cycle; the memory may acknowledge in the request cycle (zero wait) or any later cycle.
REQ-007 While a request is pending and no redirect occurs, mem_req and mem_addr SHALL stay stable.
- This holds because count cannot rise without an ack.
REQ-008 On a completed fetch, {mem_rdata, fpc} SHALL be written at the tail, and fpc SHALL increment by 1 modulo 2^AW (0xFFFF wraps to 0x0000).
REQ-009 out_valid SHALL be (count != 0) && !redirect.
- out_insn and out_pc SHALL show the head entry combinationally.
- Their values are don't-care when out_valid=0.
REQ-010 A pop SHALL occur when out_valid && out_ready.
REQ-011 A simultaneous push and pop SHALL leave count unchanged and advance both pointers.
- A push can never occur when count=DEPTH.
REQ-012 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-013 Fetch latency: a word acked in cycle N SHALL appear with out_valid=1 in cycle N+1 when the queue was empty.
REQ-014 Redirect SHALL take priority over everything except rst. In a redirect cycle:
- any mem_ack SHALL be ignored and the data discarded;
- no pop SHALL occur;
- the next state SHALL be count=0, pointers reset, fpc=redirect_pc.
REQ-015 A request abandoned by redirect (mem_req dropping without an ack) SHALL be treated by the memory as cancelled.
REQ-016 Back-to-back redirects SHALL each reload fpc; the last one wins.
REQ-017 With zero-wait memory and out_ready held high, the block SHALL sustain one instruction per cycle.

Reset
REQ-018 While rst=1 the block SHALL drive mem_req=0 and out_valid=0.
REQ-019 Reset SHALL set count=0, head=tail=0 and fpc=0.
REQ-020 rst SHALL override redirect and mem_ack in the same cycle.
REQ-021 In the first cycle after reset, mem_req=1 and mem_addr=0x0000.
REQ-022 Reset asserted mid-operation (request pending, queue non-empty) SHALL discard all entries and the pending request.

Verification
REQ-023 Reset then zero-wait memory returning insn=addr^0xA5A5 with out_ready=1 -> mem_addr 0,1,2,... on consecutive cycles; out_pc 0,1,2,... one cycle later with matching out_insn.
REQ-024 out_ready=0 with zero-wait memory -> 4 fetches (addr 0..3), then mem_req=0 with count=4. Pulse out_ready for one cycle -> pop of pc 0; the next cycle mem_req=1 at addr 4.
REQ-025 mem_ack delayed 3 cycles -> mem_req=1 and mem_addr=0x0002 held stable for all 3 wait cycles; exactly one entry is pushed on the ack cycle.
REQ-026 Three entries queued, redirect=1 to 0x1234 with mem_ack=1 in the same cycle -> next cycle out_valid=0 and mem_addr=0x1234. The acked word never appears; the first out_pc after the flush is 0x1234.
REQ-027 Redirect to 0xFFFF -> fetches at 0xFFFF then 0x0000; out_pc sequence is 0xFFFF, 0x0000.
REQ-028 rst asserted for one cycle with a full queue and redirect=1 -> mem_req=0 during rst; the next cycle out_valid=0 and mem_addr=0x0000, with the redirect ignored.
